// File: rtl/serial_shift_ctrl.sv
// Purpose: frames a parallel word into a serial bit stream (ser_bit/ser_en with first/last markers).
// Latency: first bit one cycle after accept; frame_done one cycle after the last bit.
// Backpressure: in_ready low while shifting or gapping; with GAP=0 it rises on the last bit for gapless streaming.
module serial_shift_ctrl #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_bit,
    output logic             ser_en,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic             frame_done
);
    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LD = 8'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [7:0]       gap_cnt;
    logic             last_bit;
    logic             accept;

    // Serial outputs decode directly from registered state, so reset clears them at once.
    assign last_bit  = (state == ST_SHIFT) && (bit_cnt == LAST);
    assign ser_en    = (state == ST_SHIFT);
    assign ser_first = ser_en && (bit_cnt == '0);
    assign ser_last  = last_bit;
    assign ser_bit   = ser_en && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign busy      = (state != ST_IDLE);

    // Ready is held low while reset is asserted; without a gap the last bit doubles as an accept slot.
    assign in_ready  = rst_n && ((state == ST_IDLE) || (last_bit && (GAP == 0)));
    assign accept    = in_valid && in_ready;

    // Load/shift/gap sequencer with bit and gap counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_bit;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sreg    <= in_data;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        if (GAP == 0) begin
                            if (accept) begin
                                sreg    <= in_data;
                                bit_cnt <= '0;
                                state   <= ST_SHIFT;
                            end else begin
                                sreg    <= '0;
                                bit_cnt <= '0;
                                state   <= ST_IDLE;
                            end
                        end else begin
                            sreg    <= '0;
                            bit_cnt <= '0;
                            gap_cnt <= GAP_LD;
                            state   <= ST_GAP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (MSB_FIRST) begin
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                        end else begin
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                        end
                    end
                end
                ST_GAP: begin
                    // Gap occupies exactly gap_cnt cycles, counted down to 1.
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
